quadrature_decoder: RTL and testbench

Converts a two-phase quadrature signal (A/B) from an incremental encoder into a one-cycle `step` pulse and a `up` direction level. It sits directly upstream of the team's up/down counter: `up` drives the counter's `up` input, and `step` is its count-enable. The block synchronizes and glitch-filters the asynchronous A/B inputs and flags illegal transitions.

---
 rtl/quadrature_decoder.sv | 144 ++++++++++++++
 tb/tb_quadrature_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: 2-flop synchronizers, per-channel run-length glitch
// filters, Gray-sequence decode into step/up pulses and a sticky error flag.

module quadrature_decoder_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic dout_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // The counter holds how many consecutive samples have disagreed with the
    // filtered value; the FILTER_LEN-th disagreeing sample commits the change.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (din_i != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = din_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout_o = filt_q;
endmodule

module quadrature_decoder #(
    parameter int FILTER_LEN = 3,
    parameter int MODE       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       err_clr,
    output logic       step,
    output logic       up,
    output logic       err,
    output logic [1:0] state
);
    generate
        if (!(MODE == 1 || MODE == 2 || MODE == 4)) begin : g_bad_mode
            $error("quadrature_decoder: MODE must be 1, 2 or 4");
        end
        if (FILTER_LEN < 1) begin : g_bad_filter
            $error("quadrature_decoder: FILTER_LEN must be >= 1");
        end
    endgenerate

    logic [1:0] sync1_q, sync2_q, prev_q, filt;
    logic       step_q, step_d, up_q, up_d, err_q, err_d;
    logic [1:0] diff;
    logic       valid, illegal, dir_fwd, counted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {a_in, b_in};
            sync2_q <= sync1_q;
        end
    end

    quadrature_decoder_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .din_i   (sync2_q[1]),
        .dout_o  (filt[1])
    );

    quadrature_decoder_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .din_i   (sync2_q[0]),
        .dout_o  (filt[0])
    );

    // Successor of a state in the forward (A leads B) Gray sequence.
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always_comb begin
        diff    = filt ^ prev_q;
        valid   = ^diff;
        illegal = &diff;
        dir_fwd = (filt == fwd_next(prev_q));
        if (MODE == 4) begin
            counted = valid;
        end else if (MODE == 2) begin
            counted = valid & diff[1];
        end else begin
            // Only the 00<->10 edge: A changed while B sat low on both sides.
            counted = valid & diff[1] & ~prev_q[0] & ~filt[0];
        end
        step_d = enable & counted;
        up_d   = step_d ? dir_fwd : up_q;
        err_d  = (enable & illegal) | (err_q & ~err_clr);
    end

    // prev tracks unconditionally so disabled transitions are never replayed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 2'b00;
            step_q <= 1'b0;
            up_q   <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            prev_q <= filt;
            step_q <= step_d;
            up_q   <= up_d;
            err_q  <= err_d;
        end
    end

    assign step  = step_q;
    assign up    = up_q;
    assign err   = err_q;
    assign state = filt;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized and directed bench for quadrature_decoder (MODE 4 and MODE 1
// instances side by side) against a window-based behavioural model.

module tb_quadrature_decoder;
    localparam int F = 3;

    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic a_in = 1'b0, b_in = 1'b0, err_clr = 1'b0;
    logic step4, up4, err4, step1, up1, err1;
    logic [1:0] st4, st1;

    int vectors = 0, miscompares = 0, cyc = 0, sc4 = 0, sc1 = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    quadrature_decoder #(.FILTER_LEN(F), .MODE(4)) u_m4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .a_in(a_in), .b_in(b_in),
        .err_clr(err_clr), .step(step4), .up(up4), .err(err4), .state(st4)
    );

    quadrature_decoder #(.FILTER_LEN(F), .MODE(1)) u_m1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .a_in(a_in), .b_in(b_in),
        .err_clr(err_clr), .step(step1), .up(up1), .err(err1), .state(st1)
    );

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mh[0] is the raw input seen at the latest edge, mh[k] k edges earlier.
    logic [1:0] mh [0:F];
    logic [1:0] mfilt, mprev;
    logic       mstep [2], mup [2], merr [2];
    logic [1:0] gcode [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic int gpos(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= F; k++) mh[k] = 2'b00;
        mfilt = 2'b00;
        mprev = 2'b00;
        for (int m = 0; m < 2; m++) begin
            mstep[m] = 1'b0;
            mup[m]   = 1'b1;
            merr[m]  = 1'b0;
        end
    endtask

    task automatic model_clock();
        int pp, pc, d;
        bit counted, all_diff;
        logic [1:0] nf;
        pp = gpos(mprev);
        pc = gpos(mfilt);
        d  = (pc - pp + 4) % 4;   // 1 forward, 3 reverse, 2 illegal
        for (int m = 0; m < 2; m++) begin
            if (m == 0) counted = (d == 1 || d == 3);
            else        counted = (pp == 0 && pc == 1) || (pp == 1 && pc == 0);
            mstep[m] = enable && counted;
            if (mstep[m]) mup[m] = (d == 1);
            if (enable && d == 2) merr[m] = 1'b1;
            else if (err_clr)     merr[m] = 1'b0;
        end
        mprev = mfilt;
        // A channel flips once the last F synchronized samples (inputs from
        // 2..F+1 edges ago) all disagree with its filtered value.
        nf = mfilt;
        for (int ch = 0; ch < 2; ch++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= F; k++) if (mh[k][ch] == mfilt[ch]) all_diff = 1'b0;
            if (all_diff) nf[ch] = ~mfilt[ch];
        end
        mfilt = nf;
        for (int k = F; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = {a_in, b_in};
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_clock();
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (step4) sc4 <= sc4 + 1;
            if (step1) sc1 <= sc1 + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            check("m4.step",  int'(step4), int'(mstep[0]));
            check("m4.up",    int'(up4),   int'(mup[0]));
            check("m4.err",   int'(err4),  int'(merr[0]));
            check("m4.state", int'(st4),   int'(mfilt));
            check("m1.step",  int'(step1), int'(mstep[1]));
            check("m1.up",    int'(up1),   int'(mup[1]));
            check("m1.err",   int'(err1),  int'(merr[1]));
            check("m1.state", int'(st1),   int'(mfilt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new {A,B}, hold it; optionally pin the MODE-4 step latency.
    task automatic move(input logic [1:0] ab, input int hold, input bit timed);
        int c0;
        bit seen;
        {a_in, b_in} = ab;
        c0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (timed && step4 && !seen) begin
                seen = 1'b1;
                check("latency", cyc - c0, F + 3);
            end
            @(posedge clk);
            #1;
        end
        if (timed && !seen) check("step_seen", 0, 1);
    endtask

    task automatic fwd_cycle(input bit timed);
        move(2'b10, 10, timed);
        move(2'b11, 10, timed);
        move(2'b01, 10, timed);
        move(2'b00, 10, timed);
    endtask

    initial begin
        int s4, s1, p, r;
        enable = 1'b1;
        tick(3);
        check("rst.step",  int'(step4), 0);
        check("rst.up",    int'(up4),   1);
        check("rst.err",   int'(err4),  0);
        check("rst.state", int'(st4),   0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(10);

        s4 = sc4; s1 = sc1;
        fwd_cycle(1'b1);
        check("fwd.steps",    sc4 - s4, 4);
        check("fwd.up",       int'(up4), 1);
        check("fwd.err",      int'(err4), 0);
        check("m1.fwd.steps", sc1 - s1, 1);

        s4 = sc4; s1 = sc1;
        move(2'b01, 10, 1'b1);
        check("rev.up_first", int'(up4), 0);
        move(2'b11, 10, 1'b1);
        move(2'b10, 10, 1'b1);
        move(2'b00, 10, 1'b1);
        check("rev.steps",    sc4 - s4, 4);
        check("rev.state",    int'(st4), 0);
        check("m1.rev.steps", sc1 - s1, 1);
        check("m1.rev.up",    int'(up1), 0);

        s4 = sc4;
        a_in = 1'b1; tick(2); a_in = 1'b0; tick(10);
        check("glitch2.steps", sc4 - s4, 0);
        check("glitch2.state", int'(st4), 0);
        a_in = 1'b1; tick(3); a_in = 1'b0; tick(2);
        check("glitch3.state", int'(st4), 2);
        tick(12);
        check("glitch3.steps", sc4 - s4, 2);

        s4 = sc4;
        {a_in, b_in} = 2'b11; tick(10);
        check("ill.err",   int'(err4), 1);
        check("ill.steps", sc4 - s4, 0);
        check("ill.state", int'(st4), 3);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("clr.err", int'(err4), 0);
        {a_in, b_in} = 2'b00; tick(5);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("setwins.err", int'(err4), 1);
        tick(10);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;

        s1 = sc1;
        fwd_cycle(1'b0);
        check("m1.en.steps", sc1 - s1, 1);
        enable = 1'b0;
        s1 = sc1; s4 = sc4;
        fwd_cycle(1'b0);
        check("dis.steps4", sc4 - s4, 0);
        check("dis.steps1", sc1 - s1, 0);
        enable = 1'b1;
        tick(10);
        check("reen.steps1", sc1 - s1, 0);
        move(2'b10, 10, 1'b0);
        check("m1.next.steps", sc1 - s1, 1);
        move(2'b00, 10, 1'b0);

        p = 0;
        for (int it = 0; it < 400; it++) begin
            enable  = ($urandom_range(0, 9) != 0);
            err_clr = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 11);
            if (r == 0) begin
                p = (p + 2) % 4;
            end else if (r == 1) begin
                {a_in, b_in} = gcode[p] ^ 2'b10;
                tick($urandom_range(1, 2));
                {a_in, b_in} = gcode[p];
            end else if (r < 7) begin
                p = (p + 1) % 4;
            end else begin
                p = (p + 3) % 4;
            end
            {a_in, b_in} = gcode[p];
            tick(1);
            err_clr = 1'b0;
            tick($urandom_range(F + 1, 12));
        end
        enable = 1'b1;

        {a_in, b_in} = 2'b11; tick(10);
        reset_n = 1'b0; #1;
        check("midrst.step",  int'(step4), 0);
        check("midrst.up",    int'(up4),   1);
        check("midrst.err",   int'(err4),  0);
        check("midrst.state", int'(st4),   0);
        tick(3);
        {a_in, b_in} = 2'b00; tick(2);
        s4 = sc4; s1 = sc1;
        reset_n = 1'b1;
        tick(15);
        check("rel.steps4", sc4 - s4, 0);
        check("rel.steps1", sc1 - s1, 0);
        check("rel.err",    int'(err4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
